rfi_flagger: RTL and testbench
==============================

// Module: rfi_flagger
// PURPOSE
//  Downstream of rfi_detection: per channel, compares the correlation output against a
//  programmable fraction of the power output and raises an RFI flag. Each channel keeps a
//  hold-off counter in block RAM, so a flag persists for hold_len spectra after the last hit.
//  Also reports the number of flagged channels per spectrum to software.
// PARAMETERS
//  DIN_WIDTH     18  width of pow_data/corr_data (unsigned, same binary point for both)
//  CHANNEL_ADDR  9   log2(channels per spectrum); channel counter and hold-RAM address width
//  THRESH_WIDTH  16  width of thresh (unsigned)
//  THRESH_POINT  15  binary point of thresh (ratio = thresh/2^THRESH_POINT)
//  HOLD_WIDTH    8   width of per-channel hold counter and hold_len
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  async active-low reset
//  pow_data     in   DIN_WIDTH          accumulated power (rfi_detection pow_data)
//  corr_data    in   DIN_WIDTH          accumulated correlation (rfi_detection corr_data)
//  din_valid    in   1                  one channel per valid cycle
//  sync_in      in   1                  spectrum start; next valid sample is channel 0
//  thresh       in   THRESH_WIDTH       ratio threshold (software register)
//  hold_len     in   HOLD_WIDTH         spectra a flag is held after the last hit
//  ready        out  1                  1 once the hold-RAM clear sweep is done
//  flag_out     out  1                  final flag for chan_out
//  chan_out     out  CHANNEL_ADDR       channel index of flag_out
//  flag_valid   out  1                  flag_out/chan_out qualifier
//  flag_count   out  CHANNEL_ADDR+1     flagged channels in the last complete spectrum
//  count_valid  out  1                  one-cycle pulse when flag_count updates
// BEHAVIOUR
//  - Reset: every output 0; FSM=CLEAR; channel counter=0; running count=0.
//  - FSM CLEAR: write 0 to hold-RAM addresses 0..2^CHANNEL_ADDR-1, one per cycle, ignoring
//    din_valid and sync_in. After the last address, go to WAIT_SYNC and set ready=1.
//  - WAIT_SYNC: ignore din_valid until sync_in=1, then go to RUN.
//  - RUN: sync_in sets the channel counter and running count to 0. If sync_in and din_valid
//    are high in the same cycle, that sample is channel 0. Each valid sample takes the
//    current channel, then the counter increments and wraps at 2^CHANNEL_ADDR-1 -> 0.
//  - Raw hit: corr_data*2^THRESH_POINT > pow_data*thresh, strictly greater, evaluated at
//    full DIN_WIDTH+THRESH_WIDTH width with no truncation.
//    pow=0, corr>0 -> hit. Both 0 -> no hit. thresh=0 -> hit whenever corr>0.
//  - Hold RAM (read-modify-write per channel):
//      hit              -> write hold_len
//      no hit, cnt>0    -> write cnt-1
//      no hit, cnt=0    -> write 0
//    flag_out = hit | (cnt_read != 0), where cnt_read is the value before the update.
//    hold_len=0 makes flags purely instantaneous.
//  - Pipeline (fixed 3 cycles, din_valid -> flag_valid):
//      S1: register both products and the channel; issue the RAM read
//      S2: compare; RAM data available
//      S3: RAM write-back; register flag_out, chan_out, flag_valid
//    Gaps in din_valid are allowed; all stages carry a valid bit.
//    Back-to-back different channels carry no RAW hazard. The same channel repeats no
//    sooner than 2^CHANNEL_ADDR valid cycles later.
//  - Count: running count += flag_out on each flag_valid. When the chan_out=2^CHANNEL_ADDR-1
//    output is produced, flag_count is loaded in the following cycle with the count including
//    that channel, count_valid pulses for 1 cycle, and the running count is cleared. If
//    sync_in arrives mid-spectrum, the partial count is discarded and count_valid does not
//    pulse.
//  - thresh and hold_len are sampled at S1 and S3 respectively; a change mid-spectrum
//    applies from the next sample.
//  - rst_n low mid-operation: aborts everything, in-flight samples are lost, and CLEAR reruns.
// TESTING
//  1. Release reset, CHANNEL_ADDR=3 -> ready=0 for 8 cycles, then ready=1; din_valid before
//     the first sync_in gives no flag_valid.
//  2. thresh=0x4000 (0.5): pow=100/corr=51 -> flag=1 after 3 cycles; pow=100/corr=50 -> flag=0
//     (strict compare).
//  3. hold_len=2, channel 5 hit in spectrum 0 only -> ch5 flag=1 in spectra 0,1,2 and 0 in
//     spectrum 3; other channels stay 0.
//  4. 3 of 8 channels hit, hold_len=0 -> flag_count=3 with a single count_valid pulse one
//     cycle after chan_out=7.
//  5. Edge ratios: pow=0/corr=0 -> 0; pow=0/corr=1 -> 1; full-scale pow and corr with
//     thresh=0xFFFF -> no overflow, flag=0.
//  6. sync_in after 4 channels, or rst_n pulse mid-spectrum -> no count_valid for the partial
//     spectrum; the next valid sample is chan_out=0; after reset, hold counters read 0.

Source files
------------

// File: rtl/rfi_flagger.sv
// Per-channel RFI flagger: ratio test of correlation against power, with a per-channel
// hold-off counter in block RAM and a per-spectrum flagged-channel count.
module rfi_flagger #(
  parameter int DIN_WIDTH    = 18,
  parameter int CHANNEL_ADDR = 9,
  parameter int THRESH_WIDTH = 16,
  parameter int THRESH_POINT = 15,
  parameter int HOLD_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIN_WIDTH-1:0]    pow_data,
  input  logic [DIN_WIDTH-1:0]    corr_data,
  input  logic                    din_valid,
  input  logic                    sync_in,
  input  logic [THRESH_WIDTH-1:0] thresh,
  input  logic [HOLD_WIDTH-1:0]   hold_len,
  output logic                    ready,
  output logic                    flag_out,
  output logic [CHANNEL_ADDR-1:0] chan_out,
  output logic                    flag_valid,
  output logic [CHANNEL_ADDR:0]   flag_count,
  output logic                    count_valid
);

  localparam int PROD_W = DIN_WIDTH + THRESH_WIDTH;
  localparam int DEPTH  = 1 << CHANNEL_ADDR;
  localparam logic [CHANNEL_ADDR-1:0] LAST_CHAN = '1;

  typedef enum logic [1:0] {CLEAR, WAIT_SYNC, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [CHANNEL_ADDR-1:0] clr_addr_reg, clr_addr_next;
  logic                    ready_reg;

  // Input acceptance and channel counter
  logic                    sync_seen, take_sample, sample_first;
  logic [CHANNEL_ADDR-1:0] cur_chan;
  logic [CHANNEL_ADDR-1:0] chan_cnt_reg, chan_cnt_next;
  logic                    first_pend_reg, first_pend_next;

  // Pipeline stage registers
  logic                    s1_valid_reg, s1_first_reg;
  logic [CHANNEL_ADDR-1:0] s1_chan_reg;
  logic [PROD_W-1:0]       s1_corr_reg, s1_pow_reg;
  logic                    s2_valid_reg, s2_first_reg, s2_hit_reg;
  logic [CHANNEL_ADDR-1:0] s2_chan_reg;
  logic                    flag_valid_reg, flag_out_reg, first_out_reg;
  logic [CHANNEL_ADDR-1:0] chan_out_reg;

  // Hold RAM
  logic [HOLD_WIDTH-1:0]   hold_ram [DEPTH];
  logic [HOLD_WIDTH-1:0]   ram_rd_reg;
  logic                    ram_we;
  logic [CHANNEL_ADDR-1:0] ram_wa;
  logic [HOLD_WIDTH-1:0]   ram_wd;
  logic [HOLD_WIDTH-1:0]   cnt_new;
  logic                    flag_new;

  // Spectrum count
  logic [CHANNEL_ADDR:0]   run_cnt_reg, run_cnt_next;
  logic [CHANNEL_ADDR:0]   flag_count_reg, flag_count_next;
  logic                    count_valid_reg, count_valid_next;
  logic [CHANNEL_ADDR:0]   cnt_sum;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= CLEAR;
      clr_addr_reg <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_addr_reg <= clr_addr_next;
      ready_reg    <= (state_next != CLEAR);
    end
  end

  always_comb begin
    state_next    = state_reg;
    clr_addr_next = clr_addr_reg;
    case (state_reg)
      CLEAR: begin
        clr_addr_next = clr_addr_reg + 1'b1;
        if (clr_addr_reg == LAST_CHAN) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: if (sync_in) state_next = RUN;
      RUN:       state_next = RUN;
      default:   state_next = CLEAR;
    endcase
  end

  // ---------------- channel counter ----------------
  // The first sample after a sync carries a tag so the count restarts exactly where the
  // new spectrum reaches the output, regardless of what is still in flight.
  always_comb begin
    sync_seen       = sync_in && (state_reg != CLEAR);
    take_sample     = din_valid && ((state_reg == RUN) || (state_reg == WAIT_SYNC && sync_in));
    cur_chan        = sync_seen ? '0 : chan_cnt_reg;
    sample_first    = sync_seen || first_pend_reg;
    chan_cnt_next   = chan_cnt_reg;
    first_pend_next = first_pend_reg;
    if (take_sample) begin
      chan_cnt_next   = cur_chan + 1'b1;
      first_pend_next = 1'b0;
    end else if (sync_seen) begin
      chan_cnt_next   = '0;
      first_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_cnt_reg   <= '0;
      first_pend_reg <= 1'b0;
    end else begin
      chan_cnt_reg   <= chan_cnt_next;
      first_pend_reg <= first_pend_next;
    end
  end

  // ---------------- pipeline control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      s1_first_reg   <= 1'b0;
      s1_chan_reg    <= '0;
      s2_valid_reg   <= 1'b0;
      s2_first_reg   <= 1'b0;
      s2_chan_reg    <= '0;
      s2_hit_reg     <= 1'b0;
      flag_valid_reg <= 1'b0;
      flag_out_reg   <= 1'b0;
      first_out_reg  <= 1'b0;
      chan_out_reg   <= '0;
    end else begin
      s1_valid_reg   <= take_sample;
      s1_first_reg   <= take_sample && sample_first;
      s1_chan_reg    <= cur_chan;
      s2_valid_reg   <= s1_valid_reg;
      s2_first_reg   <= s1_first_reg;
      s2_chan_reg    <= s1_chan_reg;
      s2_hit_reg     <= s1_corr_reg > s1_pow_reg;
      flag_valid_reg <= s2_valid_reg;
      flag_out_reg   <= s2_valid_reg && flag_new;
      first_out_reg  <= s2_valid_reg && s2_first_reg;
      chan_out_reg   <= s2_chan_reg;
    end
  end

  // Both sides of the ratio test at full width: corr*2^P versus pow*thresh.
  always_ff @(posedge clk) begin
    s1_corr_reg <= PROD_W'(corr_data) << THRESH_POINT;
    s1_pow_reg  <= PROD_W'(pow_data) * PROD_W'(thresh);
  end

  // ---------------- hold RAM read-modify-write ----------------
  always_comb begin
    flag_new = s2_hit_reg || (ram_rd_reg != '0);
    cnt_new  = '0;
    if (s2_hit_reg)              cnt_new = hold_len;
    else if (ram_rd_reg != '0)   cnt_new = ram_rd_reg - 1'b1;
    ram_we = (state_reg == CLEAR) || s2_valid_reg;
    ram_wa = (state_reg == CLEAR) ? clr_addr_reg : s2_chan_reg;
    ram_wd = (state_reg == CLEAR) ? '0 : cnt_new;
  end

  always_ff @(posedge clk) begin
    if (ram_we) hold_ram[ram_wa] <= ram_wd;
    ram_rd_reg <= hold_ram[s1_chan_reg];
  end

  // ---------------- per-spectrum flag count ----------------
  always_comb begin
    run_cnt_next     = run_cnt_reg;
    flag_count_next  = flag_count_reg;
    count_valid_next = 1'b0;
    cnt_sum          = (first_out_reg ? '0 : run_cnt_reg) + {{CHANNEL_ADDR{1'b0}}, flag_out_reg};
    if (flag_valid_reg) begin
      if (chan_out_reg == LAST_CHAN) begin
        flag_count_next  = cnt_sum;
        count_valid_next = 1'b1;
        run_cnt_next     = '0;
      end else begin
        run_cnt_next = cnt_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_reg     <= '0;
      flag_count_reg  <= '0;
      count_valid_reg <= 1'b0;
    end else begin
      run_cnt_reg     <= run_cnt_next;
      flag_count_reg  <= flag_count_next;
      count_valid_reg <= count_valid_next;
    end
  end

  assign ready       = ready_reg;
  assign flag_out    = flag_out_reg;
  assign chan_out    = chan_out_reg;
  assign flag_valid  = flag_valid_reg;
  assign flag_count  = flag_count_reg;
  assign count_valid = count_valid_reg;

endmodule

// File: tb/tb_rfi_flagger.sv
// Directed bench for rfi_flagger with 8 channels per spectrum.
module tb_rfi_flagger;
  localparam int DW = 18, CA = 3, TW = 16, TP = 15, HW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] pow_data = '0, corr_data = '0;
  logic          din_valid = 1'b0, sync_in = 1'b0;
  logic [TW-1:0] thresh = 16'h4000;
  logic [HW-1:0] hold_len = '0;
  logic          ready, flag_out, flag_valid, count_valid;
  logic [CA-1:0] chan_out;
  logic [CA:0]   flag_count;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, ch7_cyc = -100, cv_cyc = -100;
  logic q_flag[$];
  int   q_chan[$];
  int   cq[$];

  rfi_flagger #(.DIN_WIDTH(DW), .CHANNEL_ADDR(CA), .THRESH_WIDTH(TW),
                .THRESH_POINT(TP), .HOLD_WIDTH(HW)) dut (
    .clk(clk), .rst_n(rst_n), .pow_data(pow_data), .corr_data(corr_data),
    .din_valid(din_valid), .sync_in(sync_in), .thresh(thresh), .hold_len(hold_len),
    .ready(ready), .flag_out(flag_out), .chan_out(chan_out), .flag_valid(flag_valid),
    .flag_count(flag_count), .count_valid(count_valid));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output recorder: every flag and count event, sampled mid-cycle.
  always @(negedge clk) begin
    if (flag_valid) begin
      q_flag.push_back(flag_out);
      q_chan.push_back(int'(chan_out));
      if (chan_out == 3'd7) ch7_cyc = cyc;
    end
    if (count_valid) begin
      cq.push_back(int'(flag_count));
      cv_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
    $display("check %-16s observed=%0h required=%0h", tag, obs, req);
  endtask

  task automatic clear_q;
    q_flag.delete(); q_chan.delete(); cq.delete();
  endtask

  task automatic send(input logic [DW-1:0] p, input logic [DW-1:0] c, input logic [TW-1:0] t);
    pow_data = p; corr_data = c; thresh = t; din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
  endtask

  task automatic pulse_sync;
    sync_in = 1'b1; tick; sync_in = 1'b0;
  endtask

  // Eight channels at ratio 0.5: corr 600 of 1000 hits, corr 400 does not.
  task automatic run_spectrum(input logic [7:0] mask);
    for (int ch = 0; ch < 8; ch++) send(18'd1000, mask[ch] ? 18'd600 : 18'd400, 16'h4000);
    repeat (5) tick;
  endtask

  task automatic check_spectrum(input string tag, input logic [7:0] exp_flags, input int exp_cnt);
    logic [7:0] got;
    got = '0;
    check({tag, ".n"}, q_chan.size(), 8);
    for (int i = 0; i < q_chan.size() && i < 8; i++) begin
      check({tag, ".chan"}, q_chan[i], i);
      got[i] = q_flag[i];
    end
    check({tag, ".flags"}, got, exp_flags);
    check({tag, ".ncv"}, cq.size(), 1);
    if (cq.size() > 0) check({tag, ".count"}, cq[0], exp_cnt);
    clear_q();
  endtask

  initial begin
    // 1: reset values, clear sweep, samples before sync ignored
    tick; tick;
    check("rst.ready", ready, 0);
    check("rst.fvalid", flag_valid, 0);
    check("rst.cvalid", count_valid, 0);
    check("rst.fcount", flag_count, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("clr.ready0", ready, 0);
      tick;
    end
    check("clr.ready1", ready, 1);
    send(18'd100, 18'd90, 16'h4000);
    send(18'd100, 18'd90, 16'h4000);
    send(18'd0, 18'd5, 16'h4000);
    repeat (6) tick;
    check("nosync.nflag", q_chan.size(), 0);
    clear_q();

    // 2: strict compare and 3-cycle latency
    hold_len = 8'd0;
    pulse_sync;
    send(18'd100, 18'd51, 16'h4000);
    check("lat.c1", flag_valid, 0);
    tick;
    check("lat.c2", flag_valid, 0);
    tick;
    check("lat.c3", flag_valid, 1);
    check("r51.flag", flag_out, 1);
    check("r51.chan", chan_out, 0);
    send(18'd100, 18'd50, 16'h4000);
    tick; tick;
    check("r50.valid", flag_valid, 1);
    check("r50.flag", flag_out, 0);
    check("r50.chan", chan_out, 1);
    for (int ch = 2; ch < 8; ch++) send(18'd1000, 18'd400, 16'h4000);
    repeat (5) tick;
    check("t2.ncv", cq.size(), 1);
    if (cq.size() > 0) check("t2.count", cq[0], 1);
    clear_q();

    // 3: hold-off of 2 spectra on channel 5
    hold_len = 8'd2;
    run_spectrum(8'h20); check_spectrum("hold.s0", 8'h20, 1);
    run_spectrum(8'h00); check_spectrum("hold.s1", 8'h20, 1);
    run_spectrum(8'h00); check_spectrum("hold.s2", 8'h20, 1);
    run_spectrum(8'h00); check_spectrum("hold.s3", 8'h00, 0);

    // 4: three hits, count pulse one cycle after channel 7
    hold_len = 8'd0;
    run_spectrum(8'h89);
    check("cnt.gap", cv_cyc - ch7_cyc, 1);
    check_spectrum("cnt3", 8'h89, 3);

    // 5: edge ratios, thresh changed per sample
    send(18'd0, 18'd0, 16'h4000);             // 0/0 -> no hit
    send(18'd0, 18'd1, 16'h4000);             // pow 0 -> hit
    send(18'h3FFFF, 18'h3FFFF, 16'hFFFF);     // full scale -> no hit
    send(18'd5, 18'd1, 16'h0000);             // thresh 0, corr>0 -> hit
    send(18'd5, 18'd0, 16'h0000);             // thresh 0, corr 0 -> no hit
    for (int ch = 5; ch < 8; ch++) send(18'd1000, 18'd400, 16'h4000);
    repeat (5) tick;
    check_spectrum("edge", 8'h0A, 2);

    // 6a: sync after 4 channels discards the partial count
    for (int ch = 0; ch < 4; ch++) send(18'd1000, 18'd600, 16'h4000);
    repeat (5) tick;
    check("part.n", q_chan.size(), 4);
    check("part.ncv", cq.size(), 0);
    clear_q();
    pulse_sync;
    run_spectrum(8'h41);
    check_spectrum("resync", 8'h41, 2);

    // 6b: reset mid-spectrum reruns the clear sweep
    hold_len = 8'd3;
    run_spectrum(8'h04);
    check_spectrum("prerst", 8'h04, 1);
    send(18'd1000, 18'd400, 16'h4000);
    send(18'd1000, 18'd400, 16'h4000);
    send(18'd1000, 18'd400, 16'h4000);
    rst_n = 1'b0;
    #1;
    check("arst.fvalid", flag_valid, 0);
    check("arst.ready", ready, 0);
    check("arst.fcount", flag_count, 0);
    tick; tick;
    rst_n = 1'b1;
    check("arst.ncv", cq.size(), 0);
    clear_q();
    check("rerun.ready0", ready, 0);
    repeat (7) tick;
    check("rerun.ready0b", ready, 0);
    tick;
    check("rerun.ready1", ready, 1);
    hold_len = 8'd0;
    pulse_sync;
    run_spectrum(8'h00);
    check_spectrum("postrst", 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
